// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch
//  Description : rv32 instruction fetch unit. It holds the fetch PC, keeps up
//                to DEPTH pipelined imem requests in flight, buffers returned
//                words in an in-order FIFO, and flushes on redirect.
//                Optional feature macro: IFU_MISALIGN_CHK_EN (sticky
//                misaligned-redirect fault).
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
    parameter int                  IR_WIDTH = 32,
    parameter logic [IR_WIDTH-1:0] RESET_PC = '0,
    parameter int                  DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [IR_WIDTH-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [IR_WIDTH-1:0] imem_rdata,
    input  logic                redirect,
    input  logic [IR_WIDTH-1:0] redirect_pc,
    output logic                ir_valid,
    input  logic                ir_ready,
    output logic [IR_WIDTH-1:0] ir,
    output logic [IR_WIDTH-1:0] pc,
    output logic                fetch_fault
);

    localparam int                  c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                  c_CW    = $clog2(DEPTH + 1);
    localparam logic [IR_WIDTH-1:0] c_NOP   = IR_WIDTH'(32'h0000_0013);
    localparam logic [c_CW:0]       c_LIMIT = (c_CW + 1)'(DEPTH);

    logic [IR_WIDTH-1:0] r_fetch_pc;
    logic [c_CW-1:0]     r_count;
    logic [c_CW-1:0]     r_outst;
    logic [c_CW-1:0]     r_drop;
    logic [c_AW-1:0]     r_fifo_wptr;
    logic [c_AW-1:0]     r_fifo_rptr;
    logic [c_AW-1:0]     r_pq_wptr;
    logic [c_AW-1:0]     r_pq_rptr;
    logic [IR_WIDTH-1:0] r_fifo_pc [DEPTH];
    logic [IR_WIDTH-1:0] r_fifo_ir [DEPTH];
    logic [IR_WIDTH-1:0] r_pq      [DEPTH];

    logic                w_pop_raw;
    logic                w_pop;
    logic                w_grant;
    logic                w_push;
    logic                w_drop_resp;
    logic                w_fault;
    logic [c_CW:0]       w_credit_used;
    logic [IR_WIDTH-1:0] w_redirect_pc;

`ifdef IFU_MISALIGN_CHK_EN
    logic r_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (redirect) begin
            r_fault <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign w_fault       = r_fault;
    assign w_redirect_pc = redirect_pc;
`else
    logic w_unused_pc_lsb;

    assign w_unused_pc_lsb = ^redirect_pc[1:0];
    assign w_fault         = 1'b0;
    assign w_redirect_pc   = {redirect_pc[IR_WIDTH-1:2], 2'b00};
`endif

    assign ir_valid  = (r_count != '0);
    assign ir        = ir_valid ? r_fifo_ir[r_fifo_rptr] : c_NOP;
    assign pc        = ir_valid ? r_fifo_pc[r_fifo_rptr] : '0;
    assign imem_addr = r_fetch_pc;

    // Credit counts every slot that is or will be occupied, stale or not.
    assign w_pop_raw     = ir_valid && ir_ready;
    assign w_pop         = w_pop_raw && !redirect;
    assign w_credit_used = {1'b0, r_outst} + {1'b0, r_count} - (c_CW + 1)'(w_pop_raw);
    assign imem_req      = rst_n && !redirect && !w_fault && (w_credit_used < c_LIMIT);
    assign w_grant       = imem_req && imem_gnt;
    assign w_drop_resp   = imem_rvalid && (r_drop != '0);
    assign w_push        = imem_rvalid && (r_drop == '0) && !redirect;
    assign fetch_fault   = w_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc  <= RESET_PC;
            r_count     <= '0;
            r_outst     <= '0;
            r_drop      <= '0;
            r_fifo_wptr <= '0;
            r_fifo_rptr <= '0;
            r_pq_wptr   <= '0;
            r_pq_rptr   <= '0;
        end else if (redirect) begin
            // Everything still in flight after this cycle's response is stale.
            r_fetch_pc  <= w_redirect_pc;
            r_count     <= '0;
            r_outst     <= r_outst - c_CW'(imem_rvalid);
            r_drop      <= r_outst - c_CW'(imem_rvalid);
            r_fifo_wptr <= '0;
            r_fifo_rptr <= '0;
            r_pq_wptr   <= '0;
            r_pq_rptr   <= '0;
        end else begin
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + IR_WIDTH'(4);
                r_pq_wptr  <= r_pq_wptr + c_AW'(1);
            end
            if (w_push) begin
                r_pq_rptr   <= r_pq_rptr + c_AW'(1);
                r_fifo_wptr <= r_fifo_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_fifo_rptr <= r_fifo_rptr + c_AW'(1);
            end
            if (w_drop_resp) begin
                r_drop <= r_drop - c_CW'(1);
            end
            r_outst <= r_outst + c_CW'(w_grant) - c_CW'(imem_rvalid);
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_pq[r_pq_wptr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_fifo_pc[r_fifo_wptr] <= r_pq[r_pq_rptr];
            r_fifo_ir[r_fifo_wptr] <= imem_rdata;
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && (r_count == c_CW'(DEPTH))));

endmodule
`default_nettype wire
